// File: rtl/step_controller_pkg.sv
// Shared types and default constants for the step_controller sequencer.
package step_controller_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        DONE = 3'd4
    } state_t;

    // Operation applied by step_alu to the intermediate value
    typedef enum logic [1:0] {
        OP_ADD1 = 2'd0,
        OP_SHL  = 2'd1,
        OP_ADD3 = 2'd2,
        OP_PASS = 2'd3
    } step_op_t;

    localparam logic [7:0] ADD1_DEFAULT = 8'd5;
    localparam logic [7:0] ADD3_DEFAULT = 8'd13;

endpackage

// File: rtl/step_alu.sv
// Combinational step datapath: add ADD1, double, or add ADD3.
// Optional feature macro: STEP_CONTROLLER_SAT_EN clamps each step at 255
// instead of wrapping modulo 256.
module step_alu
    import step_controller_pkg::*;
#(
    parameter logic [7:0] ADD1 = ADD1_DEFAULT,
    parameter logic [7:0] ADD3 = ADD3_DEFAULT
) (
    input  logic [7:0] operand,
    input  step_op_t   op,
    output logic [7:0] result
);

    logic [8:0] sum;

    // 9-bit step result; bit 8 is the carry out of the step
    always_comb begin
        sum = {1'b0, operand};
        case (op)
            OP_ADD1: sum = {1'b0, operand} + {1'b0, ADD1};
            OP_SHL:  sum = {operand, 1'b0};
            OP_ADD3: sum = {1'b0, operand} + {1'b0, ADD3};
            default: sum = {1'b0, operand};
        endcase
`ifdef STEP_CONTROLLER_SAT_EN
        result = sum[8] ? 8'hFF : sum[7:0];
`else
        result = sum[7:0];
`endif
    end

endmodule

// File: rtl/step_controller.sv
// Three-step arithmetic sequencer: result = ((x + ADD1) * 2 + ADD3).
// Wrap vs. saturate is selected by STEP_CONTROLLER_SAT_EN (see step_alu).
//
// state | meaning
// IDLE  | waiting for start; captures data_in on accept
// S1    | intermediate += ADD1
// S2    | intermediate <<= 1
// S3    | intermediate += ADD3, publish data_out, raise done
// DONE  | done low again, return to IDLE
module step_controller
    import step_controller_pkg::*;
#(
    parameter logic [7:0] ADD1 = ADD1_DEFAULT,
    parameter logic [7:0] ADD3 = ADD3_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       start,
    output logic [7:0] data_out,
    output logic       done
);

    state_t     state, state_next;
    logic [7:0] intermediate_reg, intermediate_next;
    logic [7:0] data_out_next;
    logic       done_next;
    step_op_t   op;
    logic [7:0] alu_result;

    step_alu #(
        .ADD1 (ADD1),
        .ADD3 (ADD3)
    ) u_alu (
        .operand (intermediate_reg),
        .op      (op),
        .result  (alu_result)
    );

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            intermediate_reg <= 8'd0;
            data_out         <= 8'd0;
            done             <= 1'b0;
        end else begin
            state            <= state_next;
            intermediate_reg <= intermediate_next;
            data_out         <= data_out_next;
            done             <= done_next;
        end
    end

    // Next-state, step select and register updates
    always_comb begin
        state_next        = state;
        intermediate_next = intermediate_reg;
        data_out_next     = data_out;
        done_next         = 1'b0;
        op                = OP_PASS;
        case (state)
            IDLE: begin
                if (start) begin
                    intermediate_next = data_in;
                    state_next        = S1;
                end
            end
            S1: begin
                op                = OP_ADD1;
                intermediate_next = alu_result;
                state_next        = S2;
            end
            S2: begin
                op                = OP_SHL;
                intermediate_next = alu_result;
                state_next        = S3;
            end
            S3: begin
                op                = OP_ADD3;
                intermediate_next = alu_result;
                data_out_next     = alu_result;
                done_next         = 1'b1;
                state_next        = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_step_controller.sv
// Directed testbench for step_controller with hand-computed results.
module tb_step_controller;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       start;
    logic [7:0] data_out;
    logic       done;

    int n_checks;
    int n_errors;
    int done_total;

    step_controller dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .start    (start),
        .data_out (data_out),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (done) done_total++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle and measure cycles from accept edge to done
    task automatic run_op(input logic [7:0] d, output int lat);
        @(negedge clk);
        data_in = d;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int snap;
    int gap;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        done_total = 0;
        rst        = 1'b1;
        start      = 1'b0;
        data_in    = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_data_out", data_out, 0);
        check("reset_done", done, 0);
        rst = 1'b0;

        // Basic operation: 10 -> 43, done after 3 edges, value holds
        run_op(8'd10, lat);
        check("lat_10", lat, 3);
        check("out_10", data_out, 43);
        @(negedge clk);
        check("done_falls", done, 0);
        check("out_10_hold", data_out, 43);

        run_op(8'd0, lat);
        check("lat_0", lat, 3);
        check("out_0", data_out, 23);

        run_op(8'd120, lat);
        check("lat_120", lat, 3);
`ifdef STEP_CONTROLLER_SAT_EN
        check("out_120", data_out, 255);
`else
        check("out_120", data_out, 7);
`endif

        run_op(8'd255, lat);
        check("lat_255", lat, 3);
`ifdef STEP_CONTROLLER_SAT_EN
        check("out_255", data_out, 255);
`else
        check("out_255", data_out, 21);
`endif

        // start pulsed during S2 is ignored
        @(negedge clk);
        snap    = done_total;
        data_in = 8'd10;
        start   = 1'b1;
        @(negedge clk);              // accepted; now S1
        start = 1'b0;
        @(negedge clk);              // now S2
        data_in = 8'd99;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("ignore_done_count", done_total - snap, 1);
        check("ignore_out", data_out, 43);

        // start held high restarts every 5 cycles
        @(negedge clk);
        data_in = 8'd0;
        start   = 1'b1;
        lat     = 0;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("held_first_done", done, 1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!done && gap < 12);
        start = 1'b0;
        check("held_period", gap, 5);
        check("held_out", data_out, 23);
        repeat (3) @(negedge clk);

        // Reset during S2 aborts the operation
        data_in = 8'd10;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);              // now S2
        rst = 1'b1;
        #1;
        check("abort_data_out", data_out, 0);
        check("abort_done", done, 0);
        snap = done_total;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_done", done_total - snap, 0);
        check("abort_out_stays", data_out, 0);

        run_op(8'd1, lat);
        check("lat_1", lat, 3);
        check("out_1", data_out, 25);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/step_controller.md
# step_controller

Three-step arithmetic sequencer: on a `start` pulse it captures an 8-bit operand and applies add, double and add over successive clock cycles. It then presents the result on `data_out` with a one-cycle `done` strobe. It is a small datapath/FSM leaf, driven by a control block that issues `start` and waits for `done`.

## Interface
- `ADD1`, default 5, constant added in step 1.
- `ADD3`, default 13, constant added in step 3.
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `data_in`  input  8  operand; sampled only on the edge where `start` is accepted.
- `start`  input  1  request; accepted only in IDLE.
- `data_out`  output  8  registered result; holds its value until the next result or reset.
- `done`  output  1  registered; high for exactly one cycle when `data_out` updates.

## Operation
- Result = ((data_in + ADD1) * 2 + ADD3) mod 256, with defaults (x+5)*2+13. Example: 10 -> 43.
- Internal registers: `state` and 8-bit `intermediate_reg`.
- State machine states: IDLE, S1, S2, S3, DONE.
- IDLE: when `start`=1, `intermediate_reg` <= data_in and go to S1. Otherwise remain in IDLE.
- S1: `intermediate_reg` <= intermediate_reg + ADD1, go to S2.
- S2: `intermediate_reg` <= intermediate_reg << 1, go to S3.
- S3: load the next value intermediate_reg + ADD3 into both `intermediate_reg` and `data_out`; set `done`; go to DONE.
- DONE: clear `done`, go to IDLE.
- Arithmetic is 8-bit; all carries are discarded (wrap-around).
- `start` is ignored in S1, S2, S3 and DONE; there is no queuing.
- `start` held high continuously restarts a new operation on the first IDLE cycle after DONE.
- Reset: `state`=IDLE, `intermediate_reg`=0, `data_out`=0, `done`=0.
- Reset asserted mid-operation aborts it immediately; no `done` is produced for the aborted operation.

## Timing
- `start` is sampled high at edge N.
- `data_out` and `done` update at edge N+3.
- `done` falls at edge N+4.
- The earliest next accepted `start` is at edge N+5, giving a throughput of one operation per 5 cycles.
- `data_out` is stable from edge N+3 until the next S3 edge, so it may be sampled one or more cycles after `done`.

## Configuration
- Macro `STEP_CONTROLLER_SAT_EN`.
- Defined: every step saturates at 255 instead of wrapping, using a 9-bit internal sum with clamp.
- Undefined (default): modulo-256 wrap as specified above.

## Structure
- The state encoding enum (IDLE, S1, S2, S3, DONE) and the default constants ADD1=5 and ADD3=13 belong in a shared package `step_controller_pkg`.
- One sub-module is natural: `step_alu`, combinational. Inputs are an 8-bit operand and a step select; output is the next `intermediate_reg` value. It contains the add/shift and the optional saturation.
- The FSM and registers stay in `step_controller`.

## Test plan
- Reset, then `start` for 1 cycle with data_in=10 -> `done` after 3 edges; `data_out`=43 and remains 43 on the following edge.
- data_in=0 -> `data_out`=23.
- data_in=120 -> `data_out`=7 (wrap). With `STEP_CONTROLLER_SAT_EN`, `data_out`=255.
- data_in=255 -> `data_out`=21 (wrap). With `STEP_CONTROLLER_SAT_EN`, `data_out`=255.
- Pulse `start` with data_in=99 during S2 of a data_in=10 operation -> ignored; result 43 and a single `done` pulse.
- Assert `rst` in S2 -> `data_out`=0, `done`=0, IDLE; a subsequent start with data_in=1 -> `data_out`=25.
